// File: rtl/booth_mul_arbiter.sv
// Round-robin arbiter that shares one radix-4 booth multiplier among NREQ requesters,
// with operand muxing, completion tracking, result routing and a watchdog timeout.
module booth_mul_arbiter #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 async_rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*32-1:0]   req_a,
    input  logic [NREQ*32-1:0]   req_b,
    output logic [NREQ-1:0]      req_ack,
    output logic                 resp_valid,
    output logic [IDW-1:0]       resp_id,
    output logic [63:0]          resp_r,
    output logic                 resp_err,
    output logic                 busy,
    output logic                 mul_valid,
    output logic [31:0]          mul_a,
    output logic [31:0]          mul_b,
    input  logic [63:0]          mul_r,
    input  logic                 mul_ready
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_LO, WAIT_HI, RESP} state_t;

    state_t            state;
    logic [IDW-1:0]    rr_ptr;
    logic [IDW-1:0]    id;
    logic [TW-1:0]     timer;
    logic [TW-1:0]     timer_inc;
    logic [1:0]        rst_pipe;
    logic              rst_n;
    logic              grant_found;
    logic [IDW-1:0]    grant_id;
    logic [NREQ-1:0]   grant_onehot;

    // Reset asserts immediately but releases only after two clean clock edges.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            rst_pipe <= '0;
        end else begin
            rst_pipe <= {rst_pipe[0], 1'b1};
        end
    end

    assign rst_n     = rst_pipe[1];
    assign timer_inc = timer + 1'b1;

    // Scan requesters starting at rr_ptr and wrapping; the first pending one wins.
    always_comb begin
        int idx;
        idx          = 0;
        grant_found  = 1'b0;
        grant_id     = '0;
        grant_onehot = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant_id    = IDW'(idx);
            end
        end
        for (int k = 0; k < NREQ; k++) begin
            grant_onehot[k] = grant_found && (grant_id == IDW'(k));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            id         <= '0;
            timer      <= '0;
            req_ack    <= '0;
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_r     <= '0;
            resp_err   <= 1'b0;
            busy       <= 1'b0;
            mul_valid  <= 1'b0;
            mul_a      <= '0;
            mul_b      <= '0;
        end else begin
            req_ack    <= '0;
            mul_valid  <= 1'b0;
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        req_ack <= grant_onehot;
                        mul_a   <= req_a[32*grant_id +: 32];
                        mul_b   <= req_b[32*grant_id +: 32];
                        id      <= grant_id;
                        busy    <= 1'b1;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    mul_valid <= 1'b1;
                    timer     <= '0;
                    state     <= WAIT_LO;
                end
                WAIT_LO: begin
                    timer <= timer_inc;
                    // Timeout wins here so the timer can never run past the limit unnoticed.
                    if (timer_inc >= TW'(TIMEOUT)) begin
                        resp_r     <= '0;
                        resp_err   <= 1'b1;
                        resp_id    <= id;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end else if (!mul_ready) begin
                        state <= WAIT_HI;
                    end
                end
                WAIT_HI: begin
                    timer <= timer_inc;
                    if (mul_ready) begin
                        resp_r     <= mul_r;
                        resp_err   <= 1'b0;
                        resp_id    <= id;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end else if (timer_inc >= TW'(TIMEOUT)) begin
                        resp_r     <= '0;
                        resp_err   <= 1'b1;
                        resp_id    <= id;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    rr_ptr <= (id == IDW'(NREQ - 1)) ? '0 : id + 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
